wave_seq_ctrl: RTL

Playlist sequencer for the waveform generator's output select. It holds a small program of (waveform code, dwell) entries and steps through them on command. It drives the 3-bit `sel` input of the waveform mux, holding each waveform for a programmed number of prescaled ticks. It then advances, and at the end of the list either stops or loops.

---
 rtl/wave_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wave_seq_ctrl.sv
// rtl/wave_seq_ctrl.sv - playlist sequencer stepping the waveform mux select through programmed entries
// Define WAVE_SEQ_LOOP_EN to honour the loop input; otherwise every sequence is one-shot.
module wave_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int PRESC_W = 16,
  parameter int DWELL_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [2:0]         wr_sel,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic               wr_ack,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  output logic [2:0]         sel,
  output logic [AW-1:0]      idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t             state;
  logic [2:0]         mem_sel   [DEPTH];
  logic [DWELL_W-1:0] mem_dwell [DEPTH];
  logic [PRESC_W-1:0] plat;
  logic [PRESC_W-1:0] pcnt;
  logic [DWELL_W-1:0] dcnt;
  logic [AW-1:0]      nidx;
  logic               tick;
  logic               list_end;
  logic               head_term;
  logic               wrap;

  // Codes 6 and 7 both have bits [2:1] set, which marks end-of-list.
  assign nidx      = idx + 1'b1;
  assign tick      = (pcnt == plat);
  assign list_end  = (idx == LAST) || (mem_sel[nidx][2:1] == 2'b11);
  assign head_term = (mem_sel[0][2:1] == 2'b11);

`ifdef WAVE_SEQ_LOOP_EN
  assign wrap = loop && !head_term;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign wrap        = 1'b0;
`endif

  // Program storage is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en && state == IDLE) begin
      mem_sel[wr_addr]   <= wr_sel;
      mem_dwell[wr_addr] <= wr_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sel    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_ack <= 1'b0;
      pcnt   <= '0;
      dcnt   <= '0;
      plat   <= '0;
    end else begin
      done   <= 1'b0;
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          wr_ack <= wr_en;
          if (start && !stop) begin
            if (head_term) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              sel   <= mem_sel[0];
              idx   <= '0;
              pcnt  <= '0;
              dcnt  <= '0;
              plat  <= prescale;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            sel   <= '0;
            idx   <= '0;
          end else if (tick) begin
            pcnt <= '0;
            if (dcnt != mem_dwell[idx]) begin
              dcnt <= dcnt + 1'b1;
            end else if (!list_end) begin
              idx  <= nidx;
              sel  <= mem_sel[nidx];
              dcnt <= '0;
            end else if (wrap) begin
              idx  <= '0;
              sel  <= mem_sel[0];
              dcnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              sel   <= '0;
              idx   <= '0;
              done  <= 1'b1;
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
